// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the weight-stationary systolic array.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Bottom-row sums of N products need log2(N) guard bits above the product.
  function automatic int acc_width(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction

  function automatic int lat(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/ws_pe.sv
// Processing element: stationary weight, rightward operand pass-through and
// downward registered multiply-accumulate.
module ws_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 17,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] a_in,
  output logic [DATA_W-1:0] a_out,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [ACC_W-1:0]  psum_out
);

  logic [DATA_W-1:0]   w_q;
  logic [2*DATA_W-1:0] a_x;
  logic [2*DATA_W-1:0] w_x;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_x;
  logic                ext_a;
  logic                ext_w;
  logic                ext_p;

  // Extending both operands to the product width makes the low half of an
  // unsigned multiply the correct two's-complement product as well.
  always_comb begin
    ext_a  = (SIGNED != 0) & a_in[DATA_W-1];
    ext_w  = (SIGNED != 0) & w_q[DATA_W-1];
    a_x    = {{DATA_W{ext_a}}, a_in};
    w_x    = {{DATA_W{ext_w}}, w_q};
    prod   = a_x * w_x;
    ext_p  = (SIGNED != 0) & prod[2*DATA_W-1];
    prod_x = {{(ACC_W-2*DATA_W){ext_p}}, prod};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q      <= '0;
      a_out    <= '0;
      psum_out <= '0;
    end else begin
      if (w_load) begin
        w_q <= w_in;
      end
      a_out    <= a_in;
      psum_out <= psum_in + prod_x;
    end
  end

endmodule

// File: rtl/ws_systolic_array.sv
// N x N weight-stationary matrix multiplier: row-wise weight load, streamed A
// rows with internal skew/de-skew, one C row per accepted A row.
//
//   state | meaning
//   IDLE  | no weights loaded since reset; waits for w_start
//   LOAD  | w_valid beats write W rows 0..N-1
//   RUN   | A rows accepted on a_valid & a_ready
//   DRAIN | no new rows; in-flight rows finish with the old weights
module ws_systolic_array
  import sa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int SIGNED = 0,
  parameter int ACC_W  = acc_width(DATA_W, N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                w_start,
  input  logic                w_valid,
  input  logic [N*DATA_W-1:0] w_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [N*DATA_W-1:0] a_data,
  output logic                c_valid,
  output logic [N*ACC_W-1:0]  c_data,
  output logic                busy
);

  localparam int LAT = lat(N);
  localparam int RW  = (N > 1) ? $clog2(N) : 1;
  localparam int IW  = $clog2(LAT + 1);

  state_t            state;
  state_t            state_n;
  logic [RW-1:0]     row_cnt;
  logic [IW-1:0]     inflight;
  logic [LAT-1:0]    vpipe;
  logic              accept;
  logic              load_beat;

  logic [DATA_W-1:0] a_gated [N];
  logic [DATA_W-1:0] a_row   [N];
  logic [DATA_W-1:0] a_h     [N][N];
  logic [ACC_W-1:0]  psum_v  [N][N];
  logic [ACC_W-1:0]  col_out [N];

  assign a_ready   = (state == RUN);
  assign accept    = a_valid & a_ready;
  // A w_start in LOAD restarts the row sequence; a coincident beat is dropped.
  assign load_beat = (state == LOAD) & w_valid & ~w_start;
  assign busy      = (state == LOAD) || (state == DRAIN) || (inflight != '0);
  assign c_valid   = vpipe[LAT-1];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (w_start) state_n = LOAD;
      LOAD:    if (load_beat && (row_cnt == RW'(N - 1))) state_n = RUN;
      RUN:     if (w_start) state_n = DRAIN;
      DRAIN:   if (inflight == '0) state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt <= '0;
    end else if ((state != LOAD) || w_start) begin
      row_cnt <= '0;
    end else if (w_valid) begin
      row_cnt <= row_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
      vpipe    <= '0;
    end else begin
      vpipe <= {vpipe[LAT-2:0], accept};
      case ({accept, c_valid})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Idle cycles feed zeros so nothing but accepted rows moves through the grid.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      a_gated[k] = accept ? a_data[k*DATA_W +: DATA_W] : '0;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_skew
    if (k == 0) begin : g_direct
      assign a_row[0] = a_gated[0];
    end else begin : g_dly
      logic [DATA_W-1:0] dly [k];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < k; i++) dly[i] <= '0;
        end else begin
          dly[0] <= a_gated[k];
          for (int i = 1; i < k; i++) dly[i] <= dly[i-1];
        end
      end
      assign a_row[k] = dly[k-1];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] a_in_pe;
      logic [ACC_W-1:0]  psum_in_pe;

      if (j == 0) begin : g_a_edge
        assign a_in_pe = a_row[k];
      end else begin : g_a_pass
        assign a_in_pe = a_h[k][j-1];
      end

      if (k == 0) begin : g_p_edge
        assign psum_in_pe = '0;
      end else begin : g_p_pass
        assign psum_in_pe = psum_v[k-1][j];
      end

      ws_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .SIGNED(SIGNED)
      ) u_pe (
        .clk     (clk),
        .reset   (reset),
        .w_load  (load_beat && (row_cnt == RW'(k))),
        .w_in    (w_data[j*DATA_W +: DATA_W]),
        .a_in    (a_in_pe),
        .a_out   (a_h[k][j]),
        .psum_in (psum_in_pe),
        .psum_out(psum_v[k][j])
      );
    end
  end

  // Column j leaves the bottom row j cycles after column 0; equalise here.
  for (genvar j = 0; j < N; j++) begin : g_deskew
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_direct
      assign col_out[j] = psum_v[N-1][j];
    end else begin : g_dly
      logic [ACC_W-1:0] dly [D];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < D; i++) dly[i] <= '0;
        end else begin
          dly[0] <= psum_v[N-1][j];
          for (int i = 1; i < D; i++) dly[i] <= dly[i-1];
        end
      end
      assign col_out[j] = dly[D-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_data <= '0;
    end else if (vpipe[LAT-2]) begin
      for (int j = 0; j < N; j++) begin
        c_data[j*ACC_W +: ACC_W] <= col_out[j];
      end
    end
  end

endmodule
